id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register directly downstream of the opcode control decoder.
- Captures the decoder's control word plus ID-stage operands each cycle and presents them to EX/MEM/WB.
- Supports stall (hold), flush (squash) and load-use bubble insertion.
- Generates the load-use hazard signal that freezes the PC and the IF/ID register.

Parameters:
DATA_W, 32, datapath width (pc+4, register data, sign-extended immediate)
REG_AW, 5, register-index width
CNT_W, 16, bubble-counter width (optional feature only)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_idex_ctrl  in  13  decoder control word, layout from arc_pkg
i_idex_valid  in  1  ID slot holds a real instruction
i_idex_pc4  in  DATA_W  pc+4 of ID instruction
i_idex_rdata1  in  DATA_W  register-file read port 1
i_idex_rdata2  in  DATA_W  register-file read port 2
i_idex_imm  in  DATA_W  sign-extended immediate
i_idex_rs  in  REG_AW  rs field of ID instruction
i_idex_rt  in  REG_AW  rt field of ID instruction
i_idex_rd  in  REG_AW  rd field of ID instruction
i_idex_stall  in  1  downstream stall: hold all contents
i_idex_flush  in  1  branch-taken squash
o_idex_ctrl  out  13  registered control word
o_idex_valid  out  1  EX slot valid
o_idex_pc4/o_idex_rdata1/o_idex_rdata2/o_idex_imm  out  DATA_W  registered operands
o_idex_rs/o_idex_rt/o_idex_rd  out  REG_AW  registered register indices
o_idex_hazard  out  1  load-use hazard: freeze PC and IF/ID

Behaviour:
- Reset: all outputs 0 immediately on i_rst rising, independent of clock. This includes ctrl, valid, data, indices and hazard. Reset mid-operation discards the in-flight instruction.
- Control word layout: [12]regdst [11]branch [10]memread [9]memtoreg [8]memwrite [7]alusrc [6]regwrite [5:4]aluop [3:0]other.
- Latency: one cycle, input to output.
- Hazard is combinational from registered state and current inputs:
  - o_idex_hazard = o_idex_valid & ctrl_q[10] & (rt_q != 0) & i_idex_valid & ((rt_q == i_idex_rs) | (rt_q == i_idex_rt)).
- Per-edge update priority, highest first:
  1. flush: ctrl <= 0, valid <= 0; data/index fields don't-care (cleared to 0).
  2. stall: every register holds. Hazard keeps reflecting the held contents.
  3. hazard: bubble. ctrl <= 0, valid <= 0, indices <= 0. The ID instruction is not consumed; it re-presents next cycle.
  4. otherwise: load all inputs. ctrl <= i_idex_valid ? i_idex_ctrl : 0; valid <= i_idex_valid.
- Simultaneous flush and stall: flush wins. A branch squash must never be held off.
- Simultaneous flush and hazard: flush wins. The hazard output may still assert for that cycle; the upstream stage sees the flush too.
- A bubble always clears regwrite, memwrite and branch, so it causes no architectural effect.
- Back-to-back loads: hazard asserts for exactly one cycle per dependent pair. After the bubble, valid_q = 0, so hazard deasserts.
- rt = $0 never triggers a hazard.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output o_idex_bubble_cnt, CNT_W bits, reset 0.
  - Increments on each edge where a hazard bubble is inserted (priority case 3 actually taken). Not incremented by flush or stall.
  - Saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- arc_pkg holds:
  - CTRL_W = 13 and the bit-position constants CTRL_REGDST … CTRL_OTHER_LSB.
  - ctrl_t packed struct matching the layout.
  - ALUOP_* constants (00 mem, 01 beq, 10 R-type, 11 immediate/other).
  - OTHER_* codes (ANDI 0001, ORI 0010, XORI 0011, BNE 0101, SLTI 0110).
- One sub-module, load_use_detect: the combinational hazard compare, so the hazard-unit bench can reuse it.

Test Plan:
1. i_rst pulsed mid-stream with ctrl = 13'h1FFF loaded -> all outputs 0 asynchronously, before the next edge.
2. LW (ctrl memread/memtoreg/regwrite/alusrc, rt = 8), then ADD with rs = 8 -> o_idex_hazard = 1 for one cycle. Next edge: o_idex_ctrl = 0, valid = 0; ADD loads the following edge; bubble_cnt = 1.
3. LW rt = 0, then ADD rs = 0 -> no hazard; ADD loads next edge.
4. i_idex_stall = 1 for 3 cycles with ADDI (aluop 11, regwrite) in EX and new inputs changing -> outputs unchanged all 3 cycles.
5. i_idex_flush = 1 and i_idex_stall = 1 on the same edge with BEQ in EX -> ctrl = 0, valid = 0.
6. i_idex_valid = 0 with nonzero i_idex_ctrl -> o_idex_ctrl = 0, valid = 0; no hazard raised against it next cycle.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared architectural definitions for the ID/EX boundary: the decoder's
// control-word layout, ALU-op and secondary opcode codes, and the update
// actions the ID/EX register can take on an edge.
package arc_pkg;

  // Control word width and bit positions.
  localparam int CTRL_W         = 13;
  localparam int CTRL_REGDST    = 12;
  localparam int CTRL_BRANCH    = 11;
  localparam int CTRL_MEMREAD   = 10;
  localparam int CTRL_MEMTOREG  = 9;
  localparam int CTRL_MEMWRITE  = 8;
  localparam int CTRL_ALUSRC    = 7;
  localparam int CTRL_REGWRITE  = 6;
  localparam int CTRL_ALUOP_MSB = 5;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_OTHER_MSB = 3;
  localparam int CTRL_OTHER_LSB = 0;

  // ALU operation class carried in ctrl[5:4].
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // Secondary opcode codes carried in ctrl[3:0].
  localparam logic [3:0] OTHER_ANDI = 4'b0001;
  localparam logic [3:0] OTHER_ORI  = 4'b0010;
  localparam logic [3:0] OTHER_XORI = 4'b0011;
  localparam logic [3:0] OTHER_BNE  = 4'b0101;
  localparam logic [3:0] OTHER_SLTI = 4'b0110;

  // Packed view of the control word, MSB first, matching the bit positions.
  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic [3:0] other;
  } ctrl_t;

  // What the ID/EX register does on the next edge, highest priority last.
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2,
    UPD_FLUSH  = 2'd3
  } idex_upd_e;

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// load_use_detect: combinational load-use hazard compare between the
// instruction sitting in EX and the instruction currently in ID. Kept as a
// separate module so the hazard-unit bench can instantiate it directly.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              hazard_o
);

  logic ex_is_load;
  logic rt_match;

  // A real load in EX writing a non-$0 register, consumed by a real ID op.
  always_comb begin
    ex_is_load = ex_valid_i & ex_memread_i & (ex_rt_i != '0);
    rt_match   = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
    hazard_o   = ex_is_load & id_valid_i & rt_match;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register behind the opcode control decoder.
// Registers the control word and ID operands, supports stall (hold), branch
// flush (squash) and load-use bubble insertion, and drives the load-use
// hazard that freezes the PC and IF/ID.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN adds a saturating counter of
// inserted load-use bubbles on o_idex_bubble_cnt.
module id_ex_pipe
  import arc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CTRL_W-1:0] i_idex_ctrl,
  input  logic              i_idex_valid,
  input  logic [DATA_W-1:0] i_idex_pc4,
  input  logic [DATA_W-1:0] i_idex_rdata1,
  input  logic [DATA_W-1:0] i_idex_rdata2,
  input  logic [DATA_W-1:0] i_idex_imm,
  input  logic [REG_AW-1:0] i_idex_rs,
  input  logic [REG_AW-1:0] i_idex_rt,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic              i_idex_stall,
  input  logic              i_idex_flush,
  output logic [CTRL_W-1:0] o_idex_ctrl,
  output logic              o_idex_valid,
  output logic [DATA_W-1:0] o_idex_pc4,
  output logic [DATA_W-1:0] o_idex_rdata1,
  output logic [DATA_W-1:0] o_idex_rdata2,
  output logic [DATA_W-1:0] o_idex_imm,
  output logic [REG_AW-1:0] o_idex_rs,
  output logic [REG_AW-1:0] o_idex_rt,
  output logic [REG_AW-1:0] o_idex_rd,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [CNT_W-1:0]  o_idex_bubble_cnt,
`endif
  output logic              o_idex_hazard
);

  ctrl_t             ctrl_q,   ctrl_d;
  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] pc4_q,    pc4_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [REG_AW-1:0] rs_q,     rs_d;
  logic [REG_AW-1:0] rt_q,     rt_d;
  logic [REG_AW-1:0] rd_q,     rd_d;

  logic      hazard;
  idex_upd_e upd;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q.memread),
    .ex_rt_i      (rt_q),
    .id_valid_i   (i_idex_valid),
    .id_rs_i      (i_idex_rs),
    .id_rt_i      (i_idex_rt),
    .hazard_o     (hazard)
  );

  // Pick this edge's action: flush beats stall beats bubble beats load.
  always_comb begin
    if (i_idex_flush) begin
      upd = UPD_FLUSH;
    end else if (i_idex_stall) begin
      upd = UPD_HOLD;
    end else if (hazard) begin
      upd = UPD_BUBBLE;
    end else begin
      upd = UPD_LOAD;
    end
  end

  // Next-state for every pipeline field according to the selected action.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves a variable unassigned (which would infer a latch).
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    pc4_d    = pc4_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    unique case (upd)
      UPD_FLUSH, UPD_BUBBLE: begin
        // A squashed slot or bubble carries no control bits, so it can never
        // write a register, write memory or redirect fetch.
        ctrl_d   = '0;
        valid_d  = 1'b0;
        pc4_d    = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
      end
      UPD_HOLD: begin
        // Everything keeps its value; defaults above already hold.
      end
      default: begin
        ctrl_d   = i_idex_valid ? ctrl_t'(i_idex_ctrl) : '0;
        valid_d  = i_idex_valid;
        pc4_d    = i_idex_pc4;
        rdata1_d = i_idex_rdata1;
        rdata2_d = i_idex_rdata2;
        imm_d    = i_idex_imm;
        rs_d     = i_idex_rs;
        rt_d     = i_idex_rt;
        rd_d     = i_idex_rd;
      end
    endcase
  end

  // Pipeline register; reset clears the whole slot so an in-flight op is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      pc4_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      pc4_q    <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Count bubbles actually inserted, sticking at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((upd == UPD_BUBBLE) && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // Bubble counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_idex_bubble_cnt = bubble_cnt_q;
`endif

  assign o_idex_ctrl   = ctrl_q;
  assign o_idex_valid  = valid_q;
  assign o_idex_pc4    = pc4_q;
  assign o_idex_rdata1 = rdata1_q;
  assign o_idex_rdata2 = rdata2_q;
  assign o_idex_imm    = imm_q;
  assign o_idex_rs     = rs_q;
  assign o_idex_rt     = rt_q;
  assign o_idex_rd     = rd_q;
  assign o_idex_hazard = hazard;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: stimulus pushes the expected EX-slot view
// for each cycle; a monitor on the falling edge pops and compares.
module tb_id_ex_pipe;
  import arc_pkg::*;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int TB_CNT_W = 3;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_valid, i_stall, i_flush;
  logic [DATA_W-1:0] i_pc4, i_r1, i_r2, i_imm;
  logic [REG_AW-1:0] i_rs, i_rt, i_rd;
  logic [CTRL_W-1:0] o_ctrl;
  logic              o_valid, o_hazard;
  logic [DATA_W-1:0] o_pc4, o_r1, o_r2, o_imm;
  logic [REG_AW-1:0] o_rs, o_rt, o_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [TB_CNT_W-1:0] o_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .CNT_W  (TB_CNT_W)
`endif
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_idex_ctrl       (i_ctrl),
    .i_idex_valid      (i_valid),
    .i_idex_pc4        (i_pc4),
    .i_idex_rdata1     (i_r1),
    .i_idex_rdata2     (i_r2),
    .i_idex_imm        (i_imm),
    .i_idex_rs         (i_rs),
    .i_idex_rt         (i_rt),
    .i_idex_rd         (i_rd),
    .i_idex_stall      (i_stall),
    .i_idex_flush      (i_flush),
    .o_idex_ctrl       (o_ctrl),
    .o_idex_valid      (o_valid),
    .o_idex_pc4        (o_pc4),
    .o_idex_rdata1     (o_r1),
    .o_idex_rdata2     (o_r2),
    .o_idex_imm        (o_imm),
    .o_idex_rs         (o_rs),
    .o_idex_rt         (o_rt),
    .o_idex_rd         (o_rd),
`ifdef ID_EX_BUBBLE_CNT_EN
    .o_idex_bubble_cnt (o_cnt),
`endif
    .o_idex_hazard     (o_hazard)
  );

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [31:0] pc4, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
    logic       stall, flush;
  } stim_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] pc4, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
  } slot_t;

  typedef struct {
    slot_t s;
    logic  hz;
    int    cnt;
    logic  chk_data;
    logic  chk_idx;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: the instruction currently occupying EX, which of its
  // fields are architecturally defined, and the bubble tally.
  slot_t ex;
  logic  ex_cd, ex_ci;
  int    cnt_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Load-use rule: a valid load in EX writing a nonzero rt read by a valid ID op.
  function automatic logic hz_of(input slot_t e, input stim_t s);
    return e.valid && e.ctrl.memread && (e.rt != 5'd0) && s.valid &&
           ((e.rt == s.rs) || (e.rt == s.rt));
  endfunction

  task automatic drive(input stim_t s);
    i_valid = s.valid;  i_ctrl = s.ctrl;  i_pc4 = s.pc4;  i_r1 = s.r1;
    i_r2 = s.r2;  i_imm = s.imm;  i_rs = s.rs;  i_rt = s.rt;  i_rd = s.rd;
    i_stall = s.stall;  i_flush = s.flush;
  endtask

  // What EX holds after the coming edge.
  task automatic advance(input stim_t s, input logic hz);
    if (s.flush) begin
      ex = '0;  ex_cd = 1'b0;  ex_ci = 1'b0;
    end else if (s.stall) begin
      // instruction stays put
    end else if (hz) begin
      ex.valid = 1'b0;  ex.ctrl = '0;  ex.rs = '0;  ex.rt = '0;  ex.rd = '0;
      ex_cd = 1'b0;  ex_ci = 1'b1;
      if (cnt_m < CNT_MAX) cnt_m++;
    end else begin
      ex.valid = s.valid;
      ex.ctrl  = s.valid ? s.ctrl : ctrl_t'('0);
      ex.pc4 = s.pc4;  ex.r1 = s.r1;  ex.r2 = s.r2;  ex.imm = s.imm;
      ex.rs = s.rs;  ex.rt = s.rt;  ex.rd = s.rd;
      ex_cd = 1'b1;  ex_ci = 1'b1;
    end
  endtask

  // One cycle: apply inputs after the edge, queue the expected view.
  task automatic step(input stim_t s, output logic hz);
    exp_t e;
    @(posedge clk); #1;
    drive(s);
    hz = hz_of(ex, s);
    e.s = ex;  e.hz = hz;  e.cnt = cnt_m;  e.chk_data = ex_cd;  e.chk_idx = ex_ci;
    sb_q.push_back(e);
    advance(s, hz);
  endtask

  function automatic stim_t mk(input logic v, input ctrl_t c, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
    stim_t s;
    s.valid = v;  s.ctrl = c;  s.rs = rs;  s.rt = rt;  s.rd = rd;
    s.pc4 = $urandom;  s.r1 = $urandom;  s.r2 = $urandom;  s.imm = $urandom;
    s.stall = 1'b0;  s.flush = 1'b0;
    return s;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"},   o_ctrl,   0);
    check({tag, "_valid"},  o_valid,  0);
    check({tag, "_pc4"},    o_pc4,    0);
    check({tag, "_r1"},     o_r1,     0);
    check({tag, "_r2"},     o_r2,     0);
    check({tag, "_imm"},    o_imm,    0);
    check({tag, "_rs"},     o_rs,     0);
    check({tag, "_rt"},     o_rt,     0);
    check({tag, "_rd"},     o_rd,     0);
    check({tag, "_hazard"}, o_hazard, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check({tag, "_cnt"},    o_cnt,    0);
`endif
  endtask

  // Monitor: compare whatever was queued for this cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ctrl",   o_ctrl,   e.s.ctrl);
        check("valid",  o_valid,  e.s.valid);
        check("hazard", o_hazard, e.hz);
        if (e.chk_idx) begin
          check("rs", o_rs, e.s.rs);
          check("rt", o_rt, e.s.rt);
          check("rd", o_rd, e.s.rd);
        end
        if (e.chk_data) begin
          check("pc4", o_pc4, e.s.pc4);
          check("r1",  o_r1,  e.s.r1);
          check("r2",  o_r2,  e.s.r2);
          check("imm", o_imm, e.s.imm);
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        check("bubble_cnt", o_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    ctrl_t c_lw, c_add, c_addi, c_beq, c_all;
    stim_t idle, s, last;
    logic  hz, last_hz;

    c_lw = '0;   c_lw.memread = 1'b1;  c_lw.memtoreg = 1'b1;  c_lw.regwrite = 1'b1;
    c_lw.alusrc = 1'b1;  c_lw.aluop = ALUOP_MEM;
    c_add = '0;  c_add.regdst = 1'b1;  c_add.regwrite = 1'b1;  c_add.aluop = ALUOP_RTYPE;
    c_addi = '0; c_addi.regwrite = 1'b1;  c_addi.alusrc = 1'b1;  c_addi.aluop = ALUOP_IMM;
    c_beq = '0;  c_beq.branch = 1'b1;  c_beq.aluop = ALUOP_BEQ;
    c_all = ctrl_t'(13'h1FFF);

    idle = '0;
    ex = '0;  ex_cd = 1'b1;  ex_ci = 1'b1;  cnt_m = 0;
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Load-use pair: one bubble, then the ADD is taken.
    step(mk(1'b1, c_lw, 5'd3, 5'd8, 5'd0), hz);
    step(mk(1'b1, c_add, 5'd8, 5'd9, 5'd10), hz);
    check("lu_hazard_seen", hz, 1'b1);
    step(mk(1'b1, c_add, 5'd8, 5'd9, 5'd10), hz);
    step(mk(1'b0, c_add, 5'd0, 5'd0, 5'd0), hz);

    // Load into $0 never stalls its consumer.
    step(mk(1'b1, c_lw, 5'd4, 5'd0, 5'd0), hz);
    step(mk(1'b1, c_add, 5'd0, 5'd0, 5'd11), hz);
    step(mk(1'b1, c_addi, 5'd2, 5'd12, 5'd0), hz);

    // Three stalled cycles with ADDI held in EX while ID inputs churn.
    for (int i = 0; i < 3; i++) begin
      s = mk(1'b1, ctrl_t'(13'($urandom)), 5'($urandom), 5'($urandom), 5'($urandom));
      s.ctrl.memread = 1'b0;
      s.stall = 1'b1;
      step(s, hz);
    end

    // BEQ in EX, then flush and stall on the same edge.
    step(mk(1'b1, c_beq, 5'd1, 5'd2, 5'd0), hz);
    s = mk(1'b1, c_add, 5'd5, 5'd6, 5'd7);
    s.flush = 1'b1;  s.stall = 1'b1;
    step(s, hz);

    // Invalid slot with a nonzero control word, then a would-be consumer.
    step(mk(1'b0, c_lw, 5'd1, 5'd13, 5'd0), hz);
    step(mk(1'b1, c_add, 5'd13, 5'd13, 5'd14), hz);
    step(idle, hz);

    // Asynchronous reset with an all-ones control word in EX and a dependent ID op.
    step(mk(1'b1, c_all, 5'd2, 5'd7, 5'd3), hz);
    @(posedge clk); #1;
    s = mk(1'b1, c_add, 5'd7, 5'd1, 5'd2);
    drive(s);
    #1;
    check("pre_rst_ctrl",   o_ctrl,   ex.ctrl);
    check("pre_rst_hazard", o_hazard, hz_of(ex, s));
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    drive(idle);
    ex = '0;  ex_cd = 1'b1;  ex_ci = 1'b1;  cnt_m = 0;
    #1;
    rst = 1'b0;

    // Random traffic; an op that drew a hazard is re-presented like a frozen IF/ID.
    last = idle;  last_hz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (last_hz && !last.flush) begin
        s = last;
      end else begin
        s = mk(($urandom_range(3) != 0), ctrl_t'(13'($urandom)),
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(31)));
      end
      s.stall = ($urandom_range(7) == 0);
      s.flush = ($urandom_range(9) == 0);
      step(s, hz);
      last = s;  last_hz = hz;
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
